// File: rtl/controller_link_tx.sv
// Debounces three buttons and sends them as 7-bit serial frames (start, 4 data, even parity, stop).
// First tx bit one cycle after launch; a launch needs pending and enable, and frames are never truncated.
module controller_link_tx #(
    parameter int CLK_HZ          = 50000000,
    parameter int BAUD            = 115200,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REFRESH_CYCLES  = 833333
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_left_n,
    input  logic       btn_right_n,
    input  logic       btn_attack_n,
    input  logic       enable,
    output logic       tx,
    output logic       busy,
    output logic       frame_sent,
    output logic [2:0] btn_state,
    output logic       tx_seq
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int BIT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_sync1;
    logic [2:0]         r_sync2;
    logic [2:0]         r_btn_state;
    logic [2:0]         r_btn_prev;
    logic [DEB_W-1:0]   r_deb_cnt [3];
    logic [REF_W-1:0]   r_refresh_cnt;
    logic [BIT_W-1:0]   r_clk_cnt;
    logic [1:0]         r_bit_idx;
    logic [3:0]         r_shift;
    logic               r_parity;
    logic               r_pending;
    logic               r_tx_seq;

    logic [2:0]         w_btn_raw;
    logic               w_bit_done;
    logic               w_launch;
    logic               w_btn_changed;
    logic               w_refresh_hit;
    logic               w_tx;
    logic               w_frame_sent;
    logic [3:0]         w_snapshot;

    // Buttons are active-low; the synchronizer holds active-high so reset means released.
    assign w_btn_raw = {~btn_attack_n, ~btn_right_n, ~btn_left_n};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_btn_state <= '0;
            r_btn_prev  <= '0;
            for (int i = 0; i < 3; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            r_sync1    <= w_btn_raw;
            r_sync2    <= r_sync1;
            r_btn_prev <= r_btn_state;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] != r_btn_state[i]) begin
                    if (r_deb_cnt[i] == DEB_LAST) begin
                        r_btn_state[i] <= r_sync2[i];
                        r_deb_cnt[i]   <= '0;
                    end else begin
                        r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                    end
                end else begin
                    r_deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_btn_changed = (r_btn_state != r_btn_prev);
    assign w_refresh_hit = (r_state == IDLE) && (r_refresh_cnt == REF_LAST);
    assign w_bit_done    = (r_clk_cnt == BIT_LAST);
    assign w_snapshot    = {~r_tx_seq, r_btn_state};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_launch     = 1'b0;
        w_tx         = 1'b1;
        w_frame_sent = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pending && enable) begin
                    w_launch    = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                w_tx = 1'b0;
                if (w_bit_done) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                w_tx = r_shift[0];
                if (w_bit_done && (r_bit_idx == 2'd3)) begin
                    w_state_nxt = PARITY;
                end
            end
            PARITY: begin
                w_tx = r_parity;
                if (w_bit_done) begin
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_bit_done) begin
                    w_frame_sent = 1'b1;
                    // Back-to-back launch keeps the line busy with no idle gap.
                    if (r_pending && enable) begin
                        w_launch    = 1'b1;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_cnt     <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_parity      <= 1'b0;
            r_tx_seq      <= 1'b0;
            r_refresh_cnt <= '0;
            r_pending     <= 1'b0;
        end else begin
            if (w_launch) begin
                r_clk_cnt <= '0;
                r_bit_idx <= '0;
                r_shift   <= w_snapshot;
                r_parity  <= ^w_snapshot;
                r_tx_seq  <= ~r_tx_seq;
            end else if (r_state == IDLE) begin
                r_clk_cnt <= '0;
            end else begin
                r_clk_cnt <= w_bit_done ? '0 : r_clk_cnt + 1'b1;
                if ((r_state == DATA) && w_bit_done) begin
                    r_bit_idx <= r_bit_idx + 1'b1;
                    r_shift   <= {1'b0, r_shift[3:1]};
                end
            end

            if (w_launch || w_refresh_hit) begin
                r_refresh_cnt <= '0;
            end else if (r_state == IDLE) begin
                r_refresh_cnt <= r_refresh_cnt + 1'b1;
            end

            // A new request in the launch cycle wins so the latest state is resent.
            if (w_btn_changed || w_refresh_hit) begin
                r_pending <= 1'b1;
            end else if (w_launch) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign tx         = w_tx;
    assign busy       = (r_state != IDLE);
    assign frame_sent = w_frame_sent;
    assign btn_state  = r_btn_state;
    assign tx_seq     = r_tx_seq;

endmodule

// File: tb/tb_controller_link_tx.sv
// Directed bench for controller_link_tx with CLKS_PER_BIT=4, DEBOUNCE_CYCLES=8, REFRESH_CYCLES=100.
module tb_controller_link_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_left_n;
    logic       btn_right_n;
    logic       btn_attack_n;
    logic       enable;
    logic       tx;
    logic       busy;
    logic       frame_sent;
    logic [2:0] btn_state;
    logic       tx_seq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    controller_link_tx #(
        .CLK_HZ          (4),
        .BAUD            (1),
        .DEBOUNCE_CYCLES (8),
        .REFRESH_CYCLES  (100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_left_n   (btn_left_n),
        .btn_right_n  (btn_right_n),
        .btn_attack_n (btn_attack_n),
        .enable       (enable),
        .tx           (tx),
        .busy         (busy),
        .frame_sent   (frame_sent),
        .btn_state    (btn_state),
        .tx_seq       (tx_seq)
    );

    // Frame bit i: 0=start, 1..4=d0..d3, 5=parity, 6=stop.
    typedef struct {
        logic [2:0] btn_n;      // {attack, right, left}, active-low
        logic [2:0] exp_state;
        logic [6:0] exp_frame;
        logic       exp_seq;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_btn(input logic [2:0] b);
        {btn_attack_n, btn_right_n, btn_left_n} = b;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b1 && n < 400);
        chk("wait_busy_timeout", {31'd0, busy}, 32'd1);
    endtask

    // Samples 28 cycles starting at the current negedge (first start-bit cycle).
    task automatic capture(output logic [6:0] fr, output logic ok);
        logic s [28];
        ok = 1'b1;
        for (int i = 0; i < 28; i++) begin
            if (i > 0) @(negedge clk);
            s[i] = tx;
            if (busy !== 1'b1) ok = 1'b0;
            if (frame_sent !== (i == 27)) ok = 1'b0;
        end
        for (int b = 0; b < 7; b++) begin
            fr[b] = s[4*b];
            for (int k = 1; k < 4; k++) begin
                if (s[4*b+k] !== s[4*b]) ok = 1'b0;
            end
        end
    endtask

    task automatic do_frame(input string name, input logic [6:0] exp_fr, input logic exp_seq);
        logic [6:0] fr;
        logic       ok;
        capture(fr, ok);
        chk({name, "_timing"}, {31'd0, ok}, 32'd1);
        chk({name, "_frame"}, {25'd0, fr}, {25'd0, exp_fr});
        chk({name, "_seq"}, {31'd0, tx_seq}, {31'd0, exp_seq});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int bad;

        vecs[0] = '{3'b011, 3'b100, 7'b1101000, 1'b0};
        vecs[1] = '{3'b010, 3'b101, 7'b1111010, 1'b1};
        vecs[2] = '{3'b100, 3'b011, 7'b1000110, 1'b0};
        vecs[3] = '{3'b000, 3'b111, 7'b1011110, 1'b1};
        vecs[4] = '{3'b111, 3'b000, 7'b1000000, 1'b0};
        vecs[5] = '{3'b101, 3'b010, 7'b1010100, 1'b1};
        vecs[6] = '{3'b111, 3'b000, 7'b1000000, 1'b0};

        rst_n  = 1'b0;
        enable = 1'b1;
        set_btn(3'b111);
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_sent", {31'd0, frame_sent}, 32'd0);
        chk("rst_btn_state", {29'd0, btn_state}, 32'd0);
        chk("rst_tx_seq", {31'd0, tx_seq}, 32'd0);

        // Refresh-driven first frame.
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 99; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("idle_after_reset", bad, 0);
        wait_busy(n);
        chk("first_launch_window", {31'd0, (99 + n >= 100) && (99 + n <= 101)}, 32'd1);
        do_frame("refresh", 7'b1110000, 1'b1);

        for (int v = 0; v < 7; v++) begin
            set_btn(vecs[v].btn_n);
            wait_busy(n);
            do_frame($sformatf("vec%0d", v), vecs[v].exp_frame, vecs[v].exp_seq);
            chk($sformatf("vec%0d_state", v), {29'd0, btn_state}, {29'd0, vecs[v].exp_state});
        end

        // Attack held 20 cycles: debounce latency, then press and release frames back to back.
        @(negedge clk);
        btn_attack_n = 1'b0;
        fork
            begin
                repeat (20) @(negedge clk);
                btn_attack_n = 1'b1;
            end
        join_none
        n = 0;
        while (btn_state[2] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("attack_debounce_cycles", n, 10);
        wait_busy(n);
        do_frame("attack_press", 7'b1011000, 1'b1);
        @(negedge clk);
        do_frame("attack_release_b2b", 7'b1000000, 1'b0);

        // Short glitch on left is rejected.
        @(negedge clk);
        btn_left_n = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (btn_state !== 3'b000 || busy !== 1'b0) bad++;
        end
        btn_left_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (btn_state !== 3'b000 || busy !== 1'b0) bad++;
        end
        chk("glitch_ignored", bad, 0);

        // Right released mid-frame: frame keeps d1=1, follow-up frame starts with no gap.
        btn_right_n = 1'b0;
        wait_busy(n);
        fork
            begin
                repeat (6) @(negedge clk);
                btn_right_n = 1'b1;
            end
        join_none
        do_frame("right_press", 7'b1010100, 1'b1);
        @(negedge clk);
        do_frame("right_release_b2b", 7'b1000000, 1'b0);

        // enable low holds the pending change until enable returns.
        enable     = 1'b0;
        btn_left_n = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) bad++;
        end
        chk("enable_low_hold", bad, 0);
        chk("enable_low_state", {29'd0, btn_state}, 32'd1);
        enable = 1'b1;
        @(negedge clk);
        chk("enable_launch_next", {31'd0, busy}, 32'd1);
        do_frame("enable_frame", 7'b1010010, 1'b1);
        btn_left_n = 1'b1;
        wait_busy(n);
        do_frame("left_release", 7'b1000000, 1'b0);

        // Reset during the data phase.
        btn_attack_n = 1'b0;
        wait_busy(n);
        repeat (6) @(negedge clk);
        chk("pre_reset_tx_d0", {31'd0, tx}, 32'd0);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", {31'd0, tx}, 32'd1);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_frame_sent", {31'd0, frame_sent}, 32'd0);
        chk("async_rst_btn_state", {29'd0, btn_state}, 32'd0);
        chk("async_rst_tx_seq", {31'd0, tx_seq}, 32'd0);
        repeat (3) @(negedge clk);
        btn_attack_n = 1'b1;
        rst_n        = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1 || tx_seq !== 1'b0 || btn_state !== 3'b000) bad++;
        end
        chk("post_reset_no_resume", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controller_link_tx.md
CONTROLLER_LINK_TX -- requirements
Module: controller_link_tx

Interface
REQ-001 CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 BAUD, default 115200, serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, 434 at defaults).
REQ-003 DEBOUNCE_CYCLES, default 500000, consecutive stable cycles required to accept a button change (10 ms).
REQ-004 REFRESH_CYCLES, default 833333, maximum idle cycles between frames (about 60 Hz).
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 btn_left_n, btn_right_n, btn_attack_n  input  1 each  raw asynchronous buttons, active-low.
REQ-008 enable  input  1  high permits launching new frames.
REQ-009 tx  output  1  serial line to the player-2 GPIO link, idle high.
REQ-010 busy  output  1  high while a frame is on the line.
REQ-011 frame_sent  output  1  one-cycle pulse on stop-bit completion.
REQ-012 btn_state  output  3  debounced state, active-high: [0]=left, [1]=right, [2]=attack.
REQ-013 tx_seq  output  1  sequence bit carried in the most recently launched frame.

Function
REQ-014 Each raw button passes through a 2-flop synchronizer; the inverted synchronized value feeds the debouncer.
REQ-015 Debounce per button:
- A counter increments while the synchronized value differs from btn_state.
- The counter clears on any cycle the values agree.
- btn_state bit flips, and the counter clears, when the counter reaches DEBOUNCE_CYCLES-1 while still differing.
REQ-016 Any change of btn_state sets a pending flag one cycle after the change.
REQ-017 Refresh counter:
- Increments every cycle while state is IDLE.
- Sets pending when it reaches REFRESH_CYCLES-1.
- Clears on every frame launch.
REQ-018 FSM states: IDLE, START, DATA, PARITY, STOP; reset state IDLE.
REQ-019 IDLE->START when pending=1 and enable=1:
- Snapshot btn_state and toggled tx_seq into a shift register.
- Clear pending.
- tx goes low on the next cycle.
REQ-020 Frame, LSB first, each bit exactly CLKS_PER_BIT cycles:
- start bit 0;
- data d0=left, d1=right, d2=attack, d3=seq;
- parity = XOR of d0..d3 (even parity);
- stop bit 1.
- Total frame length is 7*CLKS_PER_BIT cycles.
REQ-021 START->DATA after one bit time; DATA->PARITY after 4 bit times (2-bit counter wraps 3->0); PARITY->STOP after one bit time; STOP->IDLE after one bit time.
REQ-022 At STOP->IDLE, frame_sent pulses for 1 cycle. If pending=1 and enable=1 on that cycle, the FSM goes directly to START, so the next start bit follows with zero idle cycles.
REQ-023 busy is high in START, DATA, PARITY and STOP; tx is 1 in IDLE.
REQ-024 Button changes during a frame do not alter the frame in flight. They set pending, and multiple changes coalesce into one subsequent frame carrying the latest state.
REQ-025 enable=0 mid-frame does not truncate the frame. Pending is retained, and the frame launches once enable returns high.
REQ-026 tx_seq toggles exactly once per launched frame; it wraps 1->0.

Reset
REQ-027 While rst_n=0, regardless of clk:
- tx=1, busy=0, frame_sent=0, btn_state=3'b000, tx_seq=0;
- pending=0, all counters 0, FSM IDLE, synchronizers 0 (inverted-input sense = released).
REQ-028 Reset asserted mid-frame forces tx=1 immediately, and no partial frame resumes after release.
REQ-029 After rst_n deasserts, the first frame launches no earlier than REFRESH_CYCLES cycles later, unless a debounced change occurs first.

Verification
Bench parameters: CLKS_PER_BIT=4 (CLK_HZ=4, BAUD=1), DEBOUNCE_CYCLES=8, REFRESH_CYCLES=100.
REQ-030 Reset, no buttons, enable=1:
- tx=1 and busy=0 for the first 99 cycles.
- First frame, 28 cycles, reads start 0, data 0,0,0,1, parity 1, stop 1.
- frame_sent pulses; tx_seq=1.
REQ-031 btn_attack_n low for 20 cycles:
- btn_state=3'b100 within 2+8 cycles of the fall.
- Next frame data is 0,0,1,seq, with parity = 1 XOR seq.
REQ-032 btn_left_n glitches low for 5 cycles, then high: btn_state stays 000 and no change-triggered frame occurs.
REQ-033 Press right, then release right 6 cycles into the resulting frame (release debounced mid-frame):
- The frame completes with d1=1.
- A second frame starts the cycle after frame_sent, with d1=0 and tx_seq toggled.
REQ-034 enable=0 while a change occurs:
- No frame and tx=1 while enable stays low.
- On enable=1, a frame launches next cycle with the current btn_state.
REQ-035 rst_n pulsed low during the DATA state: tx=1 and busy=0 asynchronously, and btn_state=000 with tx_seq=0 after release.
